// File: rtl/complex_cycle_gen_pkg.sv
// Shared constants, state type and elaboration-time phasor math for complex_cycle_gen.
package complex_cycle_gen_pkg;

    localparam int  N_POINTS_DEF = 24;
    localparam int  DATA_W_DEF   = 16;
    localparam int  LEN_W_DEF    = 8;
    localparam real PI_R         = 3.141592653589793;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Largest positive code; the most negative code is never produced.
    function automatic int q_scale(int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    localparam int Q_SCALE_DEF = (1 << (DATA_W_DEF - 1)) - 1;

    // Taylor series on an angle folded into [-pi, pi]; rounds half away from zero.
    function automatic int phasor_code(int k, int n, int amp, bit is_sin);
        real x;
        real term;
        real sum;
        real v;
        x = 2.0 * PI_R * real'(k) / real'(n);
        if (x > PI_R) x = x - 2.0 * PI_R;
        term = is_sin ? x : 1.0;
        sum  = term;
        for (int i = 1; i <= 12; i++) begin
            if (is_sin) term = -term * x * x / real'((2 * i) * (2 * i + 1));
            else        term = -term * x * x / real'((2 * i - 1) * (2 * i));
            sum = sum + term;
        end
        v = sum * real'(amp);
        return (v >= 0.0) ? $rtoi(v + 0.5 + 1.0e-6) : -$rtoi(-v + 0.5 + 1.0e-6);
    endfunction

endpackage

// File: rtl/complex_cycle_rom.sv
// Combinational unit-circle LUT: index -> (cos, sin) scaled to signed DATA_W, built at elaboration.
module complex_cycle_rom
    import complex_cycle_gen_pkg::*;
#(
    parameter int N_POINTS = N_POINTS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int IDX_W    = $clog2(N_POINTS)
) (
    input  logic [IDX_W-1:0]         idx,
    output logic signed [DATA_W-1:0] re,
    output logic signed [DATA_W-1:0] im
);

    localparam int DEPTH = 2 ** IDX_W;

    logic signed [DATA_W-1:0] re_tab [DEPTH];
    logic signed [DATA_W-1:0] im_tab [DEPTH];

    // Unused slots above N_POINTS read as zero; the index never reaches them.
    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        if (k < N_POINTS) begin : g_pt
            localparam int RE_V = phasor_code(k, N_POINTS, q_scale(DATA_W), 1'b0);
            localparam int IM_V = phasor_code(k, N_POINTS, q_scale(DATA_W), 1'b1);
            assign re_tab[k] = DATA_W'(RE_V);
            assign im_tab[k] = DATA_W'(IM_V);
        end else begin : g_pad
            assign re_tab[k] = '0;
            assign im_tab[k] = '0;
        end
    end

    assign re = re_tab[idx];
    assign im = im_tab[idx];

endmodule

// File: rtl/complex_cycle_gen.sv
// Sequenced phasor stream generator with valid/ready output.
// Optional macro COMPLEX_CYCLE_GEN_CONJ_EN adds i_conj for negative rotation.
//
// state   | meaning
// IDLE    | waiting for i_start with nonzero length
// RUN     | streaming samples, o_valid high until the last one transfers
module complex_cycle_gen
    import complex_cycle_gen_pkg::*;
#(
    parameter int N_POINTS = N_POINTS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int IDX_W    = $clog2(N_POINTS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [IDX_W-1:0]         i_init_index,
    input  logic [IDX_W-1:0]         i_step,
    input  logic [LEN_W-1:0]         i_length,
`ifdef COMPLEX_CYCLE_GEN_CONJ_EN
    input  logic                     i_conj,
`endif
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_re,
    output logic signed [DATA_W-1:0] o_im,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_POINTS);

    // Operands are always < 2N, so one conditional subtract suffices.
    function automatic logic [IDX_W-1:0] wrap_idx(logic [IDX_W:0] v);
        return (v >= N_EXT) ? IDX_W'(v - N_EXT) : v[IDX_W-1:0];
    endfunction

    state_t                   state, state_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt, step_q;
    logic [LEN_W-1:0]         remain;
    logic                     valid, done;
    logic signed [DATA_W-1:0] re_q, im_q, rom_re, rom_im, im_sel;
    logic                     start_ok, xfer, final_xfer;

    assign start_ok   = (state == ST_IDLE) && i_start && (i_length != '0);
    assign xfer       = valid && i_ready;
    assign final_xfer = xfer && (remain == LEN_W'(1));

    always_comb begin
        idx_nxt = idx;
        if (start_ok)
            idx_nxt = wrap_idx({1'b0, i_init_index});
        else if (xfer && !final_xfer)
            idx_nxt = wrap_idx({1'b0, idx} + {1'b0, step_q});
    end

    complex_cycle_rom #(
        .N_POINTS (N_POINTS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_rom (
        .idx (idx_nxt),
        .re  (rom_re),
        .im  (rom_im)
    );

`ifdef COMPLEX_CYCLE_GEN_CONJ_EN
    logic conj_q;
    logic conj_sel;
    assign conj_sel = start_ok ? i_conj : conj_q;
    assign im_sel   = conj_sel ? -rom_im : rom_im;
`else
    assign im_sel   = rom_im;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok)   state_nxt = ST_RUN;
            ST_RUN:  if (final_xfer) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state == ST_RUN);
        o_last = valid && (remain == LEN_W'(1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx    <= '0;
            step_q <= '0;
            remain <= '0;
            valid  <= 1'b0;
            done   <= 1'b0;
            re_q   <= '0;
            im_q   <= '0;
`ifdef COMPLEX_CYCLE_GEN_CONJ_EN
            conj_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (start_ok) begin
                step_q <= wrap_idx({1'b0, i_step});
                remain <= i_length;
                idx    <= idx_nxt;
                re_q   <= rom_re;
                im_q   <= im_sel;
                valid  <= 1'b1;
`ifdef COMPLEX_CYCLE_GEN_CONJ_EN
                conj_q <= i_conj;
`endif
            end else if (final_xfer) begin
                remain <= '0;
                valid  <= 1'b0;
                done   <= 1'b1;
            end else if (xfer) begin
                idx    <= idx_nxt;
                re_q   <= rom_re;
                im_q   <= im_sel;
                remain <= remain - LEN_W'(1);
            end
        end
    end

    assign o_valid = valid;
    assign o_done  = done;
    assign o_re    = re_q;
    assign o_im    = im_q;

endmodule

// File: tb/tb_complex_cycle_gen.sv
// Scoreboard bench for complex_cycle_gen: driver queues expected samples, negedge monitor checks them.
module tb_complex_cycle_gen;

    localparam int N  = 24;
    localparam int DW = 16;
    localparam int LW = 8;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b1;
    logic conj = 1'b0;
    logic [IW-1:0] init_index = '0;
    logic [IW-1:0] step = '0;
    logic [LW-1:0] length = '0;
    logic valid, last, busy, done;
    logic signed [DW-1:0] re, im;

    always #5 clk = ~clk;

    complex_cycle_gen dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_init_index (init_index),
        .i_step       (step),
        .i_length     (length),
`ifdef COMPLEX_CYCLE_GEN_CONJ_EN
        .i_conj       (conj),
`endif
        .i_ready      (ready),
        .o_valid      (valid),
        .o_re         (re),
        .o_im         (im),
        .o_last       (last),
        .o_busy       (busy),
        .o_done       (done)
    );

    typedef struct {
        int re;
        int im;
        bit last;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    int last_cyc = -10;
    int done_seen = 0;
    int done_exp = 0;
    bit prev_stall = 1'b0;
    int prev_re, prev_im;
    bit prev_last;

    function automatic int lut(int k, bit is_sin);
        real v;
        v = (is_sin ? $sin(2.0 * 3.141592653589793 * k / N) : $cos(2.0 * 3.141592653589793 * k / N)) * 32767.0;
        return (v >= 0.0) ? $rtoi(v + 0.5 + 1.0e-6) : -$rtoi(-v + 0.5 + 1.0e-6);
    endfunction

    task automatic chk(string name, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push_k(int k, bit lst, bit cj);
        exp_t x;
        x.re   = lut(k, 1'b0);
        x.im   = cj ? -lut(k, 1'b1) : lut(k, 1'b1);
        x.last = lst;
        sb.push_back(x);
    endtask

    task automatic push_run(int init, int stp, int len, bit cj);
        for (int n = 0; n < len; n++) push_k((init + n * stp) % N, n == len - 1, cj);
        done_exp++;
    endtask

    // Called at posedge+1; start is sampled on the following edge.
    task automatic start_run(int init, int stp, int len, bit chk_lat);
        init_index = IW'(init);
        step       = IW'(stp);
        length     = LW'(len);
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (chk_lat) chk("first_valid_latency", int'(valid), 1);
    endtask

    task automatic wait_done(int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: o_done not seen within %0d cycles", budget);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) begin
                checks++;
                done_seen++;
                if (last_cyc != cyc - 1 || busy) begin
                    errors++;
                    $display("FAIL done_timing: last xfer cycle %0d, done cycle %0d, busy %0b (want %0d, 0)",
                             last_cyc, cyc, busy, cyc - 1);
                end
            end
            if (valid && prev_stall) begin
                checks++;
                if (int'(re) != prev_re || int'(im) != prev_im || last != prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: got %0d,%0d,%0b expected %0d,%0d,%0b",
                             re, im, last, prev_re, prev_im, prev_last);
                end
            end
            if (valid && ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: got %0d,%0d with empty scoreboard", re, im);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    if (int'(re) != e.re || int'(im) != e.im || last != e.last) begin
                        errors++;
                        $display("FAIL sample: got re=%0d im=%0d last=%0b expected re=%0d im=%0d last=%0b",
                                 re, im, last, e.re, e.im, e.last);
                    end
                end
                if (last) last_cyc = cyc;
            end
            prev_stall = valid && !ready;
            prev_re    = int'(re);
            prev_im    = int'(im);
            prev_last  = last;
        end
    end

    initial begin
        int base;
        int c;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_last", int'(last), 0);
        chk("reset_re", int'(re), 0);
        chk("reset_im", int'(im), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full cycle: indices 0..23 in order.
        push_run(0, 1, 24, 1'b0);
        start_run(0, 1, 24, 1'b1);
        chk("full_first_re", int'(re), 32767);
        chk("full_first_im", int'(im), 0);
        wait_done(100);

        // Wrap: 20, 1, 6, 11.
        @(posedge clk); #1;
        push_k(20, 1'b0, 1'b0);
        push_k(1, 1'b0, 1'b0);
        push_k(6, 1'b0, 1'b0);
        push_k(11, 1'b1, 1'b0);
        done_exp++;
        start_run(20, 5, 4, 1'b1);
        wait_done(50);

        // Back-to-back start issued in the o_done cycle.
        push_run(0, 2, 3, 1'b0);
        start_run(0, 2, 3, 1'b1);
        wait_done(50);

        // Backpressure mid-run.
        @(posedge clk); #1;
        push_run(3, 7, 8, 1'b0);
        start_run(3, 7, 8, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready = 1'b1;
        wait_done(50);

        // Zero-length start is ignored.
        @(posedge clk); #1;
        start_run(2, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("len0_valid", int'(valid), 0);
            chk("len0_busy", int'(busy), 0);
            @(posedge clk); #1;
        end

        // Start during RUN is ignored.
        push_run(5, 3, 6, 1'b0);
        start_run(5, 3, 6, 1'b1);
        @(posedge clk); #1;
        start_run(9, 2, 3, 1'b0);
        chk("run_restart_busy", int'(busy), 1);
        wait_done(50);

        // Reset in the middle of a 10-sample run.
        @(posedge clk); #1;
        push_run(0, 1, 10, 1'b0);
        done_exp--;
        base = pops;
        start_run(0, 1, 10, 1'b1);
        c = 0;
        while (pops < base + 5 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("midrun_pops_before_reset", pops - base, 5);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        chk("midrun_rst_valid", int'(valid), 0);
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_re", int'(re), 0);
        chk("midrun_rst_im", int'(im), 0);
        chk("midrun_rst_last", int'(last), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("post_rst_done", int'(done), 0);
        end

`ifdef COMPLEX_CYCLE_GEN_CONJ_EN
        // Conjugate rotation: index 6 gives 0 - j32767.
        push_run(6, 1, 2, 1'b1);
        conj = 1'b1;
        start_run(6, 1, 2, 1'b1);
        conj = 1'b0;
        chk("conj_im_idx6", int'(im), -32767);
        wait_done(50);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_seen, done_exp);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/complex_cycle_gen.md
# complex_cycle_gen

Sequenced unit-circle phasor generator for PUCCH cyclic-shift and phase-ramp construction. On a start command it streams `i_length` samples of e^{j·2π·k_n/N_POINTS} in signed fixed point, with k_n = (init + n·step) mod N_POINTS. The output is a valid/ready stream, one sample per cycle, so downstream sequence multipliers can stall it. It sits between the PUCCH format controller, which supplies the cyclic shift and length, and the base-sequence multiplier.

## Interface
- `N_POINTS`, 24: points per full cycle. Even, ≥ 4.
- `DATA_W`, 16: output width, format sfix`DATA_W`_En(`DATA_W`-1).
- `LEN_W`, 8: width of the sample-count input.
- `IDX_W`, $clog2(N_POINTS): derived index width. Do not override.

- `i_clk` in 1: clock; single clock domain.
- `i_rst` in 1: synchronous, active-high reset.
- `i_start` in 1: start pulse; sampled only while idle.
- `i_init_index` in IDX_W: first phase index.
- `i_step` in IDX_W: index increment per sample.
- `i_length` in LEN_W: number of samples to emit.
- `i_conj` in 1: reverse rotation direction. Present only with `COMPLEX_CYCLE_GEN_CONJ_EN`.
- `i_ready` in 1: downstream accepts the current sample.
- `o_valid` out 1: `o_re`/`o_im` hold a sample.
- `o_re`, `o_im` out DATA_W signed: real and imaginary parts of the phasor.
- `o_last` out 1: qualifies the final sample of a run.
- `o_busy` out 1: a run is in progress.
- `o_done` out 1: one-cycle pulse after the last sample is accepted.

## Operation
- States: IDLE, RUN.
- IDLE → RUN when `i_start` = 1 and `i_length` ≠ 0. On that edge:
  - latch step mod N, remaining = length, and conj (if enabled);
  - load the output registers with LUT(init mod N);
  - set `o_valid`.
- In IDLE, `i_start` with `i_length` = 0 is ignored: no output and no `o_done`.
- In RUN, `i_start` is ignored. Latched parameters do not change mid-run.
- Handshake: a sample transfers when `o_valid` & `i_ready`. On transfer with remaining > 1:
  - idx ← idx + step, minus N if the sum is ≥ N (a single conditional subtract is enough, since both operands are < N);
  - output registers ← LUT(new idx);
  - remaining decrements.
- On transfer with remaining = 1:
  - `o_valid` ← 0, `o_last` ← 0;
  - `o_done` ← 1 for one cycle;
  - state → IDLE.
- `o_last` = 1 exactly when `o_valid` and remaining = 1.
- While `o_valid` & !`i_ready`, the outputs hold stable.
- LUT contents: re = round(cos(2πk/N)·(2^(DATA_W-1)-1)), im = round(sin(2πk/N)·(2^(DATA_W-1)-1)). The most negative code never appears, so negation cannot overflow.
- Inputs `i_init_index`/`i_step` ≥ N are reduced mod N when latched.
- `o_busy` = (state == RUN).

## Timing
- Reset: state IDLE; `o_valid`, `o_last`, `o_busy`, `o_done` = 0; `o_re` = `o_im` = 0; idx and remaining = 0. All take effect on the first edge with `i_rst` high, including mid-run. Any in-flight sample is discarded and no `o_done` is produced.
- Latency: `i_start` sampled at edge t gives the first sample valid after edge t (visible in cycle t+1).
- Throughput: 1 sample/cycle while `i_ready` = 1.
- `o_done` is asserted in the cycle after the final transfer edge. `o_busy` falls in that same cycle.
- The earliest new `i_start` is accepted in the cycle `o_done` is high. Back-to-back runs leave one idle cycle between them.

## Configuration
- `COMPLEX_CYCLE_GEN_CONJ_EN` defined:
  - port `i_conj` exists and is latched at start;
  - when latched = 1, `o_im` = −LUT_im (output is e^{−j·2πk/N}); `o_re` is unchanged.
- Not defined: no `i_conj` port; rotation is always positive.

## Structure
- Package `complex_cycle_gen_pkg` holds:
  - default N_POINTS/DATA_W/LEN_W constants;
  - the state enum type;
  - the Q-format scale constant (2^(DATA_W-1)-1).
- Sub-module `complex_cycle_rom`: parametrised combinational LUT, index → (re, im), with contents generated at elaboration from N_POINTS/DATA_W.
- The top level owns the FSM, index accumulator, counter and output registers.

## Test plan
- Reset: assert `i_rst` for 2 cycles → all outputs 0 and `o_busy` = 0.
- Full cycle, defaults: init 0, step 1, length 24, `i_ready` held 1.
  - 24 consecutive samples; sample 0 = 32767 + j0, sample 6 = 0 + j32767, sample 12 = −32767 + j0.
  - `o_last` on sample 23 only; `o_done` one cycle later.
- Wrap: init 20, step 5, length 4 → indices 20, 1, 6, 11; sample 2 = 0 + j32767.
- Backpressure: `i_ready` low for 3 cycles mid-run → `o_re`/`o_im`/`o_last` stable; no index skipped or repeated.
- Ignored starts: `i_length` = 0 gives no `o_valid`; `i_start` during RUN leaves the sequence and count unchanged.
- Reset mid-run: at sample 5 of 10, `i_rst` high → outputs 0 next cycle and no `o_done`. With `COMPLEX_CYCLE_GEN_CONJ_EN` and `i_conj` = 1, index 6 → 0 − j32767.
